slave_spi: RTL
==============

// Module: slave_spi
// PURPOSE
// - Node-side SPI responder: the receiving end of the master SPI link in the interconnect network.
// - Deserialises one 32-bit instruction per chip-select frame and decodes its destination field.
// - Raises exactly one of for_self / for_left / for_right with rx_valid.
// - Shifts a 32-bit response word back to the master on miso during the same frame.
// PARAMETERS
// - WIDTH    32    frame / instruction width in bits
// - NODE_ID  4'd0  this node's address, compared against rx_instr[31:28]
// PORTS
// - clk        in   1      system clock; all state on posedge clk
// - reset      in   1      asynchronous, active-high reset
// - sclk       in   1      SPI serial clock from master, asynchronous to clk
// - cs_n       in   1      SPI chip select from master, active-low, asynchronous
// - mosi       in   1      serial data master->node, MSB first
// - miso       out  1      serial data node->master, MSB first; 0 outside a frame
// - tx_word    in   WIDTH  response word; captured when a frame starts
// - rx_instr   out  WIDTH  last good instruction; held until next good frame
// - rx_valid   out  1      one-cycle pulse: rx_instr and route flags updated
// - for_self   out  1      rx_instr[31:28] == NODE_ID; held with rx_instr
// - for_left   out  1      rx_instr[31:28] <  NODE_ID (unsigned); held
// - for_right  out  1      rx_instr[31:28] >  NODE_ID (unsigned); held
// - frame_err  out  1      one-cycle pulse: frame ended with bit count != WIDTH
// BEHAVIOUR
// - Reset: every output 0; shift registers 0; bit counter 0; state ARM; sync flops sclk=0, cs_n=1, mosi=0.
// - Sync: sclk, cs_n, mosi each pass through 2 flops. Edges come from the 2nd flop vs a 3rd (previous) copy.
//   - Input-to-event latency: 3 clk.
//   - Requirement: f_clk >= 4*f_sclk.
// - SPI mode 0: sample mosi on sclk rise; update miso on sclk fall.
// - States:
//   - ARM: wait for synced cs_n == 1; then go to IDLE. Prevents starting mid-frame after reset.
//   - IDLE: on cs_n falling edge:
//     - load tx_word into tx_shift; miso <= tx_word[WIDTH-1]; bit_cnt <= 0; go to SHIFT.
//   - SHIFT, on sclk rise: rx_shift <= {rx_shift[WIDTH-2:0], mosi_s}.
//     - bit_cnt increments, saturating at WIDTH+1.
//     - Bits arriving after WIDTH do not enter rx_shift.
//   - SHIFT, on sclk fall: tx_shift <= tx_shift << 1; miso <= next MSB.
//     - After WIDTH bits, miso holds 0.
//   - SHIFT, on cs_n rising edge, go to IDLE:
//     - bit_cnt == WIDTH: rx_instr <= rx_shift; compute route flags; rx_valid pulses the next cycle, with flags valid in that same cycle.
//     - Otherwise (short or over-long frame): frame_err pulses 1 cycle; rx_instr and flags are unchanged; miso <= 0.
// - Simultaneous events in one cycle:
//   - cs_n rise together with sclk rise: the sclk edge is ignored. The bit is not counted and the frame closes.
//   - cs_n fall together with sclk rise in IDLE: only the frame start is taken.
// - Route flags are mutually exclusive and one-hot whenever any good frame has been received.
// - reset asserted mid-frame: immediate return to the reset state.
//   - Frame is discarded, no pulses, re-arm through ARM.
// - No internal buffering: a new good frame overwrites rx_instr. Consumers must take it on rx_valid.
// STRUCTURE
// - spi_pkg:
//   - SPI_WIDTH = 32
//   - DEST_HI = 31, DEST_LO = 28
//   - state typedef / localparams: ARM, IDLE, SHIFT
// - Sub-module spi_sync: 2-flop synchroniser plus previous-value flop.
//   - Outputs: level, rise, fall.
//   - Reset value set by parameter.
//   - Instantiated 3x (mosi uses level only).
// - Top level: FSM, bit counter, rx/tx shift registers, destination compare.
// TESTING
// - Default setup: NODE_ID=4'd5, sclk period = 8 clk.
// - Frame 32'h5000_C350 -> rx_valid 1-cycle pulse, rx_instr=32'h5000_C350, for_self=1, for_left=0, for_right=0.
// - Frame 32'h3000_7530 -> for_left=1.
// - Frame 32'h9000_2710 -> for_right=1.
// - tx_word=32'hA5A5_0001 during any frame -> 32 miso bits sampled on sclk rise read back 32'hA5A5_0001; miso=0 after cs_n high.
// - Short frame (31 sclk) -> frame_err pulse, no rx_valid, rx_instr unchanged.
// - Long frame (33 sclk) -> frame_err pulse, no rx_valid, rx_instr unchanged.
// - Reset mid-frame:
//   - Assert reset after 16 bits; hold cs_n low through and after reset -> no rx_valid or frame_err.
//   - Raise cs_n, then send a full frame 32'h5000_0001 -> for_self=1, rx_valid pulses once.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants, FSM state type and route decode for the node-side SPI responder.
package spi_pkg;

  localparam int SPI_WIDTH = 32;
  localparam int DEST_HI   = 31;
  localparam int DEST_LO   = 28;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  // Route decode of a destination nibble against this node's id: {right, left, self}.
  function automatic logic [2:0] route_flags(input logic [3:0] dest, input logic [3:0] id);
    logic [2:0] flags;
    if (dest == id) begin
      flags = 3'b001;
    end else if (dest < id) begin
      flags = 3'b010;
    end else begin
      flags = 3'b100;
    end
    return flags;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser with a third "previous" flop for edge detection.
// Edges are reported from the second stage against the third, so an input change
// becomes visible as a rise/fall pulse two clocks after it arrives.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the asynchronous input through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  // Synchroniser chain registers, forced to the idle level of the line on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/slave_spi.sv
// Node-side SPI mode-0 responder: receives one instruction per chip-select frame,
// decodes its destination against NODE_ID and shifts a response word out on miso.
module slave_spi
  import spi_pkg::*;
#(
  parameter int         WIDTH   = SPI_WIDTH,
  parameter logic [3:0] NODE_ID = 4'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_word,
  output logic [WIDTH-1:0] rx_instr,
  output logic             rx_valid,
  output logic             for_self,
  output logic             for_left,
  output logic             for_right,
  output logic             frame_err
);

  localparam int             CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(WIDTH + 1);

  logic sclk_level_unused, sclk_rise_s, sclk_fall_s;
  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk),
    .level(sclk_level_unused), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .din(cs_n),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_e           state_q, state_d;
  logic [1:0]       arm_cnt_q, arm_cnt_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic             miso_q, miso_d;
  logic [WIDTH-1:0] rx_instr_q, rx_instr_d;
  logic [2:0]       flags_q, flags_d;      // {right, left, self}
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ARM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. ARM leaves only once cs_n has read high for three straight
  // cycles, which flushes the synchroniser's reset value so a chip select that was
  // already low across reset cannot look like a fresh frame start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARM: begin
        if (cs_level_s && (arm_cnt_q == 2'd2)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase
  end

  // Per-state datapath: frame load, bit shifting, and frame close / route decode.
  always_comb begin
    arm_cnt_d   = 2'd0;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    rx_instr_d  = rx_instr_q;
    flags_d     = flags_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_ARM: begin
        miso_d = 1'b0;
        if (!cs_level_s) begin
          arm_cnt_d = 2'd0;
        end else if (arm_cnt_q == 2'd2) begin
          arm_cnt_d = arm_cnt_q;
        end else begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end
      end
      ST_IDLE: begin
        // A frame start wins over any sclk edge seen in the same cycle.
        if (cs_fall_s) begin
          tx_shift_d = tx_word;
          miso_d     = tx_word[WIDTH-1];
          bit_cnt_d  = {CW{1'b0}};
        end else begin
          miso_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        // Frame close takes priority; a coincident sclk rise is not counted.
        if (cs_rise_s) begin
          miso_d = 1'b0;
          if (bit_cnt_q == CNT_FULL) begin
            rx_instr_d = rx_shift_q;
            flags_d    = route_flags(rx_shift_q[WIDTH-1 -: 4], NODE_ID);
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (sclk_rise_s) begin
            if (bit_cnt_q < CNT_FULL) begin
              rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
            end else begin
              rx_shift_d = rx_shift_q;
            end
            if (bit_cnt_q != CNT_SAT) begin
              bit_cnt_d = bit_cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
              bit_cnt_d = bit_cnt_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
          if (sclk_fall_s) begin
            tx_shift_d = tx_shift_q << 1;
            if (bit_cnt_q < CNT_FULL) begin
              miso_d = tx_shift_q[WIDTH-2];
            end else begin
              miso_d = 1'b0;
            end
          end else begin
            tx_shift_d = tx_shift_q;
          end
        end
      end
      default: begin
        miso_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt_q   <= 2'd0;
      bit_cnt_q   <= {CW{1'b0}};
      rx_shift_q  <= {WIDTH{1'b0}};
      tx_shift_q  <= {WIDTH{1'b0}};
      miso_q      <= 1'b0;
      rx_instr_q  <= {WIDTH{1'b0}};
      flags_q     <= 3'b000;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      arm_cnt_q   <= arm_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      rx_instr_q  <= rx_instr_d;
      flags_q     <= flags_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = miso_q;
  assign rx_instr  = rx_instr_q;
  assign rx_valid  = rx_valid_q;
  assign for_self  = flags_q[0];
  assign for_left  = flags_q[1];
  assign for_right = flags_q[2];
  assign frame_err = frame_err_q;

endmodule
